sram_mem_stage: RTL

SRAM_MEM_STAGE -- requirements
Module: sram_mem_stage

---
 rtl/mem_pkg.sv | 34 +++
 rtl/sram_addr_gen.sv | 36 +++
 rtl/sram_mem_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM memory stage.
// Contents: parameter defaults, the access FSM state type and the
// elaboration-time log2 helpers used to size counters and index fields.
package mem_pkg;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_WORD_W    = 32;
    localparam int DEF_SRAM_DW   = 16;
    localparam int DEF_SRAM_AW   = 18;
    localparam int DEF_WAIT      = 1;
    localparam int DEF_BASE_ADDR = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/sram_addr_gen.sv
// Combinational CPU-to-SRAM address translation.
// Ports:
//   address    - CPU byte address
//   beat       - beat number within the current word access
//   word_index - (address - BASE_ADDR) >> OFF_W, wrapping modulo 2^ADDR_W
//   sram_addr  - word_index*BEATS + beat, truncated to SRAM_AW bits
module sram_addr_gen
    import mem_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int SRAM_AW   = DEF_SRAM_AW,
    parameter int BASE_ADDR = DEF_BASE_ADDR,
    parameter int BEATS     = 2,
    parameter int BEAT_W    = 1,
    parameter int OFF_W     = 2,
    parameter int IDX_W     = ADDR_W - OFF_W
) (
    input  logic [ADDR_W-1:0]  address,
    input  logic [BEAT_W-1:0]  beat,
    output logic [IDX_W-1:0]   word_index,
    output logic [SRAM_AW-1:0] sram_addr
);

    // Wide enough that the multiply cannot wrap before the final truncation.
    localparam int PW = SRAM_AW + ADDR_W;

    logic [ADDR_W-1:0] offset;

    always_comb begin
        // Addresses below BASE_ADDR simply wrap; no range error exists.
        offset     = address - ADDR_W'(BASE_ADDR);
        word_index = IDX_W'(offset >> OFF_W);
        sram_addr  = SRAM_AW'(PW'(word_index) * PW'(BEATS) + PW'(beat));
    end

endmodule

// File: rtl/sram_mem_stage.sv
// Pipeline memory stage in front of a narrow asynchronous SRAM.
// A CPU word is moved as BEATS = WORD_W/SRAM_DW beats, least significant
// first, each beat held for WAIT+1 cycles. A one-entry read cache lets a
// repeated read of the same word complete without stalling.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   read, write     - requests (write wins when both are high)
//   address         - CPU byte address
//   writedata       - store data
//   readdata        - registered load data
//   SRAM_NOT_READY  - stall to upstream stages
//   SRAMaddress     - SRAM word address
//   SRAMWEn         - SRAM write enable, active-low
//   SRAMdata        - SRAM bidirectional data bus
//
// Stall handshake: a request is held on read/write/address/writedata until a
// cycle with SRAM_NOT_READY = 0; it is consumed at the end of that cycle.
// The request cycle itself is the first cycle of beat 0, so the SRAM pins
// are driven from the live inputs in that cycle and from the values latched
// at the IDLE->ACCESS edge afterwards. Stall length is BEATS*(WAIT+1).
module sram_mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int SRAM_DW   = DEF_SRAM_DW,
    parameter int SRAM_AW   = DEF_SRAM_AW,
    parameter int WAIT      = DEF_WAIT,     // 0..15
    parameter int BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read,
    input  logic               write,
    input  logic [ADDR_W-1:0]  address,
    input  logic [WORD_W-1:0]  writedata,
    output logic [WORD_W-1:0]  readdata,
    output logic               SRAM_NOT_READY,
    output logic [SRAM_AW-1:0] SRAMaddress,
    output logic               SRAMWEn,
    inout  wire  [SRAM_DW-1:0] SRAMdata
);

    localparam int BEATS  = WORD_W / SRAM_DW;
    localparam int OFF_W  = clog2(WORD_W / 8);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int BEAT_W = width_of(BEATS);
    localparam logic [3:0]        WAIT_LAST = 4'(WAIT);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BEAT_W-1:0] beat_q;
    logic [3:0]        wait_q;
    logic [WORD_W-1:0] rbuf_q, rbuf_d;

    logic              cache_valid;
    logic [IDX_W-1:0]  cache_idx;
    logic [WORD_W-1:0] cache_data;

    logic               in_idle, hit, start, active, is_write;
    logic               beat_end, last_beat;
    logic [ADDR_W-1:0]  gen_addr;
    logic [WORD_W-1:0]  wsrc;
    logic [SRAM_DW-1:0] wslice;
    logic [IDX_W-1:0]   cur_idx;
    logic [SRAM_AW-1:0] beat_addr;

    // In IDLE the live address is translated (hit check, first beat);
    // afterwards the latched one, so input changes are ignored.
    assign in_idle  = (state_q == ST_IDLE);
    assign gen_addr = in_idle ? address : addr_q;
    assign wsrc     = in_idle ? writedata : wdata_q;
    assign is_write = in_idle ? write : wr_q;

    sram_addr_gen #(
        .ADDR_W    (ADDR_W),
        .SRAM_AW   (SRAM_AW),
        .BASE_ADDR (BASE_ADDR),
        .BEATS     (BEATS),
        .BEAT_W    (BEAT_W),
        .OFF_W     (OFF_W),
        .IDX_W     (IDX_W)
    ) u_addr_gen (
        .address    (gen_addr),
        .beat       (beat_q),
        .word_index (cur_idx),
        .sram_addr  (beat_addr)
    );

    // rst gates start so the stall and SRAM pins drop the instant reset rises.
    assign hit       = in_idle && read && !write && cache_valid && (cache_idx == cur_idx);
    assign start     = in_idle && !rst && (write || (read && !hit));
    assign active    = start || (state_q == ST_ACCESS);
    assign beat_end  = active && (wait_q == WAIT_LAST);
    assign last_beat = (beat_q == BEAT_LAST);

    assign SRAM_NOT_READY = active;
    assign SRAMWEn        = !(active && is_write);
    assign SRAMaddress    = active ? beat_addr : '0;
    assign SRAMdata       = (active && is_write) ? wslice : 'z;

    // Beat slice selection for the bus, and slice insertion for capture.
    always_comb begin
        wslice = '0;
        rbuf_d = rbuf_q;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_q == BEAT_W'(k)) begin
                wslice                       = wsrc[k*SRAM_DW +: SRAM_DW];
                rbuf_d[k*SRAM_DW +: SRAM_DW] = SRAMdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = (beat_end && last_beat) ? ST_DONE : ST_ACCESS;
            ST_ACCESS: if (beat_end && last_beat) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            beat_q      <= '0;
            wait_q      <= '0;
            rbuf_q      <= '0;
            readdata    <= '0;
            cache_valid <= 1'b0;
            cache_idx   <= '0;
            cache_data  <= '0;
        end else begin
            if (start) begin
                addr_q  <= address;
                wr_q    <= write;
                wdata_q <= writedata;
            end

            if (active) begin
                if (beat_end) begin
                    wait_q <= '0;
                    beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
                end else begin
                    wait_q <= wait_q + 4'd1;
                end
            end else begin
                wait_q <= '0;
                beat_q <= '0;
            end

            // Slices collect in rbuf_q; readdata and the cache only change
            // when the last beat lands, so an aborted read commits nothing.
            if (active && !is_write && beat_end) begin
                rbuf_q <= rbuf_d;
                if (last_beat) begin
                    readdata    <= rbuf_d;
                    cache_valid <= 1'b1;
                    cache_idx   <= cur_idx;
                    cache_data  <= rbuf_d;
                end
            end

            if (hit) readdata <= cache_data;

            // Keep the cached copy coherent with the SRAM after a store.
            if (state_q == ST_DONE && wr_q && cache_valid && cache_idx == cur_idx)
                cache_data <= wdata_q;
        end
    end

endmodule
